cmd_router_mc: RTL and testbench

//  Multi-channel command router between cspi_codec and local/remote command sinks.

---
 rtl/cmd_router_mc.sv | 210 +++++++++++++++++++++
 tb/tb_cmd_router_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_router_mc.sv
// Command router: decodes cmd_dev and steers each command to the local fx bus
// controller, to one remote transmit FIFO, or to all remote FIFOs at once.
// It also tracks local read responses with a timeout and counts dropped commands.
module cmd_router_mc #(
    parameter int         N_CH       = 4,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] LOCAL_DEV  = 8'h00,
    parameter logic [7:0] DEV_BASE   = 8'h01,
    parameter int         RD_TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [7:0]        cmd_dev,
    input  logic [7:0]        cmd_mod,
    input  logic [7:0]        cmd_addr,
    input  logic [7:0]        cmd_data,
    input  logic              cmd_rd,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    output logic [7:0]        cmd_q,
    output logic              cmd_qvld,
    output logic              cmd_qerr,
    output logic [7:0]        cmdl_mod,
    output logic [7:0]        cmdl_addr,
    output logic [7:0]        cmdl_data,
    output logic              cmdl_wr,
    output logic              cmdl_rd,
    input  logic [7:0]        cmdl_q,
    input  logic              cmdl_qvld,
    output logic [8*N_CH-1:0] cmdr_dev,
    output logic [8*N_CH-1:0] cmdr_mod,
    output logic [8*N_CH-1:0] cmdr_addr,
    output logic [8*N_CH-1:0] cmdr_data,
    output logic [N_CH-1:0]   cmdr_vld,
    input  logic [N_CH-1:0]   cmdr_rdy,
    output logic [15:0]       drop_cnt
);

    localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              LW       = AW + 1;
    localparam logic [LW-1:0]   FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [15:0]     TO_LAST  = 16'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {L_IDLE, L_WR, L_RD, L_WAIT, L_RESP} lst_t;

    lst_t          lst_q, lst_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic [7:0]    resp_q_q, resp_q_d;
    logic          resp_err_q, resp_err_d;
    logic          ill_q;
    logic [15:0]   drop_q;
    logic [7:0]    lmod_q, laddr_q, ldata_q;

    logic [31:0]   mem_q  [N_CH][FIFO_DEPTH];
    logic [AW-1:0] wptr_q [N_CH];
    logic [AW-1:0] wptr_d [N_CH];
    logic [AW-1:0] rptr_q [N_CH];
    logic [AW-1:0] rptr_d [N_CH];
    logic [LW-1:0] lvl_q  [N_CH];
    logic [LW-1:0] lvl_d  [N_CH];

    logic [N_CH-1:0] push, pop;
    logic            any_full, acc, is_local, is_remote, is_bc, ill_rd, drop_ev;
    logic [8:0]      dev_off;
    logic [31:0]     entry;

    // Address decode of the command presented on this cycle
    always_comb begin
        any_full = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (lvl_q[k] == FULL_LVL) any_full = 1'b1;
        end
        cmd_rdy   = (lst_q == L_IDLE) && !any_full;
        acc       = cmd_vld && cmd_rdy;
        dev_off   = {1'b0, cmd_dev} - {1'b0, DEV_BASE};
        is_local  = (cmd_dev == LOCAL_DEV);
        is_remote = !is_local && (cmd_dev >= DEV_BASE) && (dev_off < 9'(N_CH));
        is_bc     = !is_local && !is_remote && (cmd_dev == 8'hFF);
        ill_rd    = acc && cmd_rd && (is_remote || is_bc);
        drop_ev   = acc && !is_local && (cmd_rd || !(is_remote || is_bc));
        entry     = {cmd_dev, cmd_mod, cmd_addr, cmd_data};
        push      = '0;
        for (int k = 0; k < N_CH; k++) begin
            push[k] = acc && !cmd_rd && (is_bc || (is_remote && dev_off == 9'(k)));
        end
    end

    // Local FSM next state and read-response capture
    always_comb begin
        lst_d      = lst_q;
        wcnt_d     = wcnt_q;
        resp_q_d   = resp_q_q;
        resp_err_d = resp_err_q;
        case (lst_q)
            L_IDLE: if (acc && is_local) lst_d = cmd_rd ? L_RD : L_WR;
            L_WR:   lst_d = L_IDLE;
            L_RD: begin
                lst_d  = L_WAIT;
                wcnt_d = '0;
            end
            L_WAIT: begin
                if (cmdl_qvld) begin
                    resp_q_d   = cmdl_q;
                    resp_err_d = 1'b0;
                    lst_d      = L_RESP;
                end else if (wcnt_q == TO_LAST) begin
                    resp_q_d   = 8'hEE;
                    resp_err_d = 1'b1;
                    lst_d      = L_RESP;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            L_RESP:  lst_d = L_IDLE;
            default: lst_d = L_IDLE;
        endcase
    end

    // Local FSM, response, local bus and drop counter registers
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            lst_q      <= L_IDLE;
            wcnt_q     <= '0;
            resp_q_q   <= '0;
            resp_err_q <= 1'b0;
            ill_q      <= 1'b0;
            drop_q     <= '0;
            lmod_q     <= '0;
            laddr_q    <= '0;
            ldata_q    <= '0;
        end else begin
            lst_q      <= lst_d;
            wcnt_q     <= wcnt_d;
            resp_q_q   <= resp_q_d;
            resp_err_q <= resp_err_d;
            ill_q      <= ill_rd;
            if (drop_ev && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (acc && is_local) begin
                lmod_q  <= cmd_mod;
                laddr_q <= cmd_addr;
                ldata_q <= cmd_data;
            end
        end
    end

    // FIFO pointer and level next state; push and pop may coincide
    always_comb begin
        pop = '0;
        for (int k = 0; k < N_CH; k++) begin
            pop[k]    = (lvl_q[k] != '0) && cmdr_rdy[k];
            wptr_d[k] = push[k] ? wptr_q[k] + AW'(1) : wptr_q[k];
            rptr_d[k] = pop[k]  ? rptr_q[k] + AW'(1) : rptr_q[k];
            case ({push[k], pop[k]})
                2'b10:   lvl_d[k] = lvl_q[k] + LW'(1);
                2'b01:   lvl_d[k] = lvl_q[k] - LW'(1);
                default: lvl_d[k] = lvl_q[k];
            endcase
        end
    end

    // FIFO control registers; reset empties every channel
    always_ff @(posedge clk_sys) begin
        for (int k = 0; k < N_CH; k++) begin
            if (rst) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                lvl_q[k]  <= '0;
            end else begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
                lvl_q[k]  <= lvl_d[k];
            end
        end
    end

    // FIFO storage, written at the write pointer on push
    always_ff @(posedge clk_sys) begin
        for (int k = 0; k < N_CH; k++) begin
            if (push[k]) mem_q[k][wptr_q[k]] <= entry;
        end
    end

    // Output decode; remote heads read as zero while their FIFO is empty
    always_comb begin
        cmdr_dev  = '0;
        cmdr_mod  = '0;
        cmdr_addr = '0;
        cmdr_data = '0;
        cmdr_vld  = '0;
        for (int k = 0; k < N_CH; k++) begin
            cmdr_vld[k] = (lvl_q[k] != '0);
            if (cmdr_vld[k]) begin
                cmdr_dev[8*k +: 8]  = mem_q[k][rptr_q[k]][31:24];
                cmdr_mod[8*k +: 8]  = mem_q[k][rptr_q[k]][23:16];
                cmdr_addr[8*k +: 8] = mem_q[k][rptr_q[k]][15:8];
                cmdr_data[8*k +: 8] = mem_q[k][rptr_q[k]][7:0];
            end
        end
        cmd_qvld  = (lst_q == L_RESP) || ill_q;
        cmd_qerr  = ill_q || ((lst_q == L_RESP) && resp_err_q);
        cmd_q     = ill_q ? 8'hEE : ((lst_q == L_RESP) ? resp_q_q : 8'h00);
        cmdl_wr   = (lst_q == L_WR);
        cmdl_rd   = (lst_q == L_RD);
        cmdl_mod  = lmod_q;
        cmdl_addr = laddr_q;
        cmdl_data = ldata_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_cmd_router_mc.sv
// Testbench for cmd_router_mc: per-cycle directed vectors plus hand-written
// sequences for local read latency, timeout, FIFO fill/drain and mid-run reset.
module tb_cmd_router_mc;

    localparam int N_CH = 4;

    logic              clk_sys = 1'b0;
    logic              rst;
    logic [7:0]        cmd_dev, cmd_mod, cmd_addr, cmd_data;
    logic              cmd_rd, cmd_vld;
    logic              cmd_rdy;
    logic [7:0]        cmd_q;
    logic              cmd_qvld, cmd_qerr;
    logic [7:0]        cmdl_mod, cmdl_addr, cmdl_data;
    logic              cmdl_wr, cmdl_rd;
    logic [7:0]        cmdl_q;
    logic              cmdl_qvld;
    logic [8*N_CH-1:0] cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data;
    logic [N_CH-1:0]   cmdr_vld;
    logic [N_CH-1:0]   cmdr_rdy;
    logic [15:0]       drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    cmd_router_mc #(
        .N_CH(N_CH), .FIFO_DEPTH(8), .LOCAL_DEV(8'h00), .DEV_BASE(8'h01), .RD_TIMEOUT(16)
    ) dut (
        .clk_sys(clk_sys), .rst(rst),
        .cmd_dev(cmd_dev), .cmd_mod(cmd_mod), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_rd(cmd_rd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_q(cmd_q), .cmd_qvld(cmd_qvld), .cmd_qerr(cmd_qerr),
        .cmdl_mod(cmdl_mod), .cmdl_addr(cmdl_addr), .cmdl_data(cmdl_data),
        .cmdl_wr(cmdl_wr), .cmdl_rd(cmdl_rd), .cmdl_q(cmdl_q), .cmdl_qvld(cmdl_qvld),
        .cmdr_dev(cmdr_dev), .cmdr_mod(cmdr_mod), .cmdr_addr(cmdr_addr), .cmdr_data(cmdr_data),
        .cmdr_vld(cmdr_vld), .cmdr_rdy(cmdr_rdy), .drop_cnt(drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  dev, mod, addr, data;
        logic        rd, vld;
        logic [7:0]  lq;
        logic        lqv;
        logic [3:0]  rrdy;
        logic        e_rdy, e_wr, e_rdl, e_qv, e_qe;
        logic [7:0]  e_q;
        logic [3:0]  e_rvld;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vt [17];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        cmd_dev = 8'h00; cmd_mod = 8'h00; cmd_addr = 8'h00; cmd_data = 8'h00;
        cmd_rd = 1'b0; cmd_vld = 1'b0; cmdl_q = 8'h00; cmdl_qvld = 1'b0;
    endtask

    initial begin
        int n;
        int seen;

        // dev  mod    addr   data   rd vld lq    lqv rrdy | rdy wr rdl qv qe q   rvld drop
        vt[0]  = '{8'h00, 8'h02, 8'h10, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd0};
        vt[1]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd0};
        vt[2]  = '{8'h40, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd1};
        vt[3]  = '{8'h02, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEE, 4'h0, 16'd2};
        vt[4]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd2};
        vt[5]  = '{8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEE, 4'h0, 16'd3};
        vt[6]  = '{8'hFF, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'hF, 16'd3};
        vt[7]  = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd3};
        vt[8]  = '{8'h03, 8'h00, 8'h00, 8'h77, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h4, 16'd3};
        vt[9]  = '{8'h04, 8'h00, 8'h00, 8'h88, 1'b0, 1'b1, 8'h00, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h8, 16'd3};
        vt[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd3};
        vt[11] = '{8'h00, 8'h07, 8'h21, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 16'd3};
        vt[12] = '{8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd3};
        vt[13] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd3};
        vt[14] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 4'h0, 16'd3};
        vt[15] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h99, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd3};
        vt[16] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 16'd3};

        // Reset state
        idle_in();
        cmdr_rdy = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_qvld", {31'd0, cmd_qvld}, 32'd0);
        chk("rst_cmdl_wr", {31'd0, cmdl_wr}, 32'd0);
        chk("rst_cmdr_vld", {28'd0, cmdr_vld}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_cmdl_mod", {24'd0, cmdl_mod}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", {31'd0, cmd_rdy}, 32'd1);

        // Per-cycle directed vectors
        for (int i = 0; i < 17; i++) begin
            cmd_dev = vt[i].dev; cmd_mod = vt[i].mod; cmd_addr = vt[i].addr;
            cmd_data = vt[i].data; cmd_rd = vt[i].rd; cmd_vld = vt[i].vld;
            cmdl_q = vt[i].lq; cmdl_qvld = vt[i].lqv; cmdr_rdy = vt[i].rrdy;
            tick();
            chk($sformatf("v%0d_rdy", i), {31'd0, cmd_rdy}, {31'd0, vt[i].e_rdy});
            chk($sformatf("v%0d_wr", i), {31'd0, cmdl_wr}, {31'd0, vt[i].e_wr});
            chk($sformatf("v%0d_rdl", i), {31'd0, cmdl_rd}, {31'd0, vt[i].e_rdl});
            chk($sformatf("v%0d_qvld", i), {31'd0, cmd_qvld}, {31'd0, vt[i].e_qv});
            chk($sformatf("v%0d_qerr", i), {31'd0, cmd_qerr}, {31'd0, vt[i].e_qe});
            chk($sformatf("v%0d_q", i), {24'd0, cmd_q}, {24'd0, vt[i].e_q});
            chk($sformatf("v%0d_rvld", i), {28'd0, cmdr_vld}, {28'd0, vt[i].e_rvld});
            chk($sformatf("v%0d_drop", i), {16'd0, drop_cnt}, {16'd0, vt[i].e_drop});
            if (i == 0) begin
                chk("t1_cmdl_fields", {8'd0, cmdl_mod, cmdl_addr, cmdl_data}, 32'h0002105A);
            end
            if (i == 6) begin
                chk("bcast_data", cmdr_data, 32'hA5A5A5A5);
            end
            if (i == 8) begin
                chk("ch2_head", {16'd0, cmdr_dev[23:16], cmdr_data[23:16]}, 32'h00000377);
            end
        end
        chk("rd_cmdl_fields", {16'd0, cmdl_mod, cmdl_addr}, 32'h00000721);
        idle_in();
        cmdr_rdy = '0;

        // Local read answered on the fifth wait cycle
        cmd_dev = 8'h00; cmd_rd = 1'b1; cmd_vld = 1'b1;
        tick();
        chk("t2_cmdl_rd", {31'd0, cmdl_rd}, 32'd1);
        idle_in();
        tick();
        seen = 0;
        repeat (4) begin
            tick();
            if (cmd_qvld) seen++;
        end
        chk("t2_no_early_qvld", seen, 0);
        cmdl_qvld = 1'b1; cmdl_q = 8'h3C;
        tick();
        chk("t2_resp", {22'd0, cmd_qvld, cmd_qerr, cmd_q}, {22'd0, 1'b1, 1'b0, 8'h3C});
        idle_in();
        tick();
        chk("t2_single", {30'd0, cmd_qvld, cmd_rdy}, 32'd1);

        // Data arriving on the last wait cycle beats the timeout
        cmd_dev = 8'h00; cmd_rd = 1'b1; cmd_vld = 1'b1;
        tick();
        idle_in();
        tick();
        seen = 0;
        repeat (15) begin
            tick();
            if (cmd_qvld) seen++;
        end
        chk("edge_no_early_qvld", seen, 0);
        cmdl_qvld = 1'b1; cmdl_q = 8'hC3;
        tick();
        chk("edge_data_wins", {22'd0, cmd_qvld, cmd_qerr, cmd_q}, {22'd0, 1'b1, 1'b0, 8'hC3});
        idle_in();
        tick();

        // Timeout with no response
        cmd_dev = 8'h00; cmd_rd = 1'b1; cmd_vld = 1'b1;
        tick();
        idle_in();
        tick();
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (cmd_qvld) begin
                n = c;
                break;
            end
        end
        chk("t3_timeout_cycles", n, 16);
        chk("t3_resp", {22'd0, cmd_qvld, cmd_qerr, cmd_q}, {22'd0, 1'b1, 1'b1, 8'hEE});
        tick();
        chk("t3_back_idle", {30'd0, cmd_qvld, cmd_rdy}, 32'd1);

        // Fill channel 0, then drain in order
        cmd_dev = 8'h01; cmd_mod = 8'h09; cmd_rd = 1'b0; cmd_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_data = 8'h10 + 8'(i);
            tick();
        end
        chk("t4_full_rdy", {31'd0, cmd_rdy}, 32'd0);
        cmd_data = 8'h18;
        tick();
        chk("t4_ninth_blocked", {31'd0, cmd_rdy}, 32'd0);
        idle_in();
        cmdr_rdy = 4'h1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_pop%0d", i), {15'd0, cmdr_vld[0], cmdr_dev[7:0], cmdr_data[7:0]},
                {15'd0, 1'b1, 8'h01, 8'h10 + 8'(i)});
            tick();
        end
        chk("t4_drained", {27'd0, cmd_rdy, cmdr_vld}, {27'd0, 1'b1, 4'h0});
        cmdr_rdy = '0;

        // Reset in the middle of a pending read with a queued remote command
        cmd_dev = 8'h02; cmd_data = 8'h11; cmd_vld = 1'b1;
        tick();
        chk("mr_pushed", {28'd0, cmdr_vld}, 32'h2);
        cmd_dev = 8'h00; cmd_rd = 1'b1;
        tick();
        idle_in();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mr_rst_outputs", {26'd0, cmd_qvld, cmdl_rd, cmdr_vld}, 32'd0);
        chk("mr_rst_drop", {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mr_rdy_after", {31'd0, cmd_rdy}, 32'd1);
        seen = 0;
        repeat (25) begin
            tick();
            if (cmd_qvld) seen++;
        end
        chk("mr_no_stale_resp", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
